// File: rtl/rtlola_hlc_scheduler.sv
// High-level controller for the RTLola monitor: timestamps events, raises periodic
// deadlines, queues merged evaluation entries and steps the LLC through its stages.
module rtlola_hlc_scheduler #(
  parameter int DATA_W     = 64,
  parameter int TS_W       = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_STAGES = 4,
  parameter int PERIOD_C   = 50,
  parameter int PERIOD_D   = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             input_a,
  input  logic                          new_input,
  output logic                          hlc_valid,
  output logic [DATA_W-1:0]             hlc_a,
  output logic                          hlc_enB,
  output logic                          hlc_enC,
  output logic                          hlc_enD,
  output logic [TS_W-1:0]               hlc_ts,
  output logic [$clog2(NUM_STAGES)-1:0] llc_stage,
  output logic                          llc_busy,
  output logic                          fifo_full,
  output logic [15:0]                   dropped_cnt
);

  localparam int STAGE_W = $clog2(NUM_STAGES);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TC_W    = $clog2(PERIOD_C);
  localparam int TD_W    = $clog2(PERIOD_D);
  localparam int ENTRY_W = TS_W + DATA_W + 3;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e                 state_q;
  logic [STAGE_W-1:0]     stage_q;
  logic                   busy_q, valid_q;
  logic [TS_W-1:0]        tick_q, ts_q;
  logic [DATA_W-1:0]      last_a_q, a_q;
  logic                   due_b_q, due_c_q, due_d_q;
  logic [TC_W-1:0]        tmr_c_q;
  logic [TD_W-1:0]        tmr_d_q;
  logic [ENTRY_W-1:0]     fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [15:0]            dropped_q;

  logic                   due_c_s, due_d_s, trig_s, can_issue_s, pop_s, push_s, drop_s;
  logic [DATA_W-1:0]      a_in_s;
  logic [ENTRY_W-1:0]     entry_s, head_s;

  // Trigger merging and FIFO handshake; a pop frees a slot for a same-cycle push when full
  always_comb begin
    due_c_s     = (tmr_c_q == '0);
    due_d_s     = (tmr_d_q == '0);
    trig_s      = new_input | due_c_s | due_d_s;
    a_in_s      = new_input ? input_a : last_a_q;
    entry_s     = {tick_q, a_in_s, new_input, due_c_s, due_d_s};
    head_s      = fifo_q[rd_ptr_q];
    can_issue_s = (state_q == S_IDLE) || (stage_q == STAGE_W'(NUM_STAGES - 1));
    pop_s       = en && (count_q != '0) && can_issue_s;
    push_s      = en && trig_s && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_s);
    drop_s      = en && trig_s && !push_s;
    count_d     = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Tick counter, deadline timers and the last accepted value of a
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q   <= '0;
      tmr_c_q  <= TC_W'(PERIOD_C - 1);
      tmr_d_q  <= TD_W'(PERIOD_D - 1);
      last_a_q <= '0;
    end else if (en) begin
      tick_q   <= tick_q + TS_W'(1);
      tmr_c_q  <= due_c_s ? TC_W'(PERIOD_C - 1) : tmr_c_q - TC_W'(1);
      tmr_d_q  <= due_d_s ? TD_W'(PERIOD_D - 1) : tmr_d_q - TD_W'(1);
      last_a_q <= a_in_s;
    end else begin
      tick_q   <= tick_q;
      tmr_c_q  <= tmr_c_q;
      tmr_d_q  <= tmr_d_q;
      last_a_q <= last_a_q;
    end
  end

  // Entry FIFO storage, pointers and saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= entry_s;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop_s && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
    end
  end

  // Sequencer: issue entries to the LLC and walk its stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ts_q    <= '0;
      a_q     <= '0;
      due_b_q <= 1'b0;
      due_c_q <= 1'b0;
      due_d_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (en) begin
        if (pop_s) begin
          state_q <= S_RUN;
          stage_q <= '0;
          busy_q  <= 1'b1;
          valid_q <= 1'b1;
          {ts_q, a_q, due_b_q, due_c_q, due_d_q} <= head_s;
        end else if (state_q == S_RUN) begin
          if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            stage_q <= stage_q + STAGE_W'(1);
          end
        end else begin
          state_q <= S_IDLE;
        end
      end
    end
  end

  assign hlc_valid   = valid_q;
  assign hlc_a       = a_q;
  assign hlc_enB     = due_b_q;
  assign hlc_enC     = due_c_q;
  assign hlc_enD     = due_d_q;
  assign hlc_ts      = ts_q;
  assign llc_stage   = stage_q;
  assign llc_busy    = busy_q;
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign dropped_cnt = dropped_q;

endmodule
